// File: rtl/regfile_wb_arb_pkg.sv
// regfile_wb_arb_pkg: shared register-file write-back definitions.
// Data/address widths, reset and write-enable polarity, zero constants and
// the write-port request record used by the write-back arbiter.
package regfile_wb_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic RST_ACTIVE = 1'b1;
  localparam logic WE_ON      = 1'b1;
  localparam logic WE_OFF     = 1'b0;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// wb_ll_fifo: queue of long-latency write-back results.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_addr/data  enqueue (caller guarantees !full)
//   pop                   dequeue head (caller guarantees !empty)
//   kill_en, kill_addr    invalidate every stored entry with that address
//   full, empty           occupancy flags
//   head_valid/addr/data  head entry (valid=0 means superseded)
//   ent_valid, ent_addr   per-slot valid/address for hazard matching
module wb_ll_fifo
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  input  logic                             kill_en,
  input  logic [ADDR_W-1:0]                kill_addr,
  output logic                             full,
  output logic                             empty,
  output logic                             head_valid,
  output logic [ADDR_W-1:0]                head_addr,
  output logic [DATA_W-1:0]                head_data,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]             wptr, rptr;
  logic [PTR_W:0]               count;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [DEPTH-1:0]             kill_mask;
  logic [DEPTH-1:0]             valid_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    assign kill_mask[g] = kill_en && (ent_addr[g] == kill_addr);
  end

  // A slot being written this cycle is unoccupied, so it never collides
  // with the kill mask; the new entry is therefore never killed on entry.
  always_comb begin
    valid_d = ent_valid & ~kill_mask;
    if (pop)  valid_d[rptr] = 1'b0;
    if (push) valid_d[wptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      ent_valid <= valid_d;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wptr] <= push_addr;
      mem_data[wptr] <= push_data;
    end
  end

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_valid = ent_valid[rptr];
  assign head_addr  = ent_addr[rptr];
  assign head_data  = mem_data[rptr];

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: register-file write-port arbiter between the MEM/WB
// pipeline and a long-latency result queue.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pipe_we/waddr/wdata         pipeline write request (always wins)
//   ll_valid/ll_ready/waddr/wdata  long-latency result handshake
//   we/waddr/wdata              registered register-file write port
//   chk_addr1/2, pend_hit1/2    decode hazard check against queued writes
//   stall_req                   asks the pipeline for a free slot
// Build option: define WB_LL_BYPASS_EN to let an ll result skip the empty
// queue and take a free slot directly (latency 1).
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_waddr,
  input  logic [DATA_W-1:0] ll_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              stall_req
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                                 pipe_real, pop, push, bypass;
  logic                                 fifo_full, fifo_empty;
  logic                                 head_valid;
  logic [ADDR_W-1:0]                    head_addr;
  logic [DATA_W-1:0]                    head_data;
  logic [FIFO_DEPTH-1:0]                ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    ent_addr;
  logic [FIFO_DEPTH-1:0]                match1, match2;
  logic [CNT_W-1:0]                     starve_cnt;
  wb_req_t                              wb_d, wb_q;

  assign pipe_real = pipe_we && (pipe_waddr != ZERO_ADDR);
  assign pop       = !pipe_real && !fifo_empty;

`ifdef WB_LL_BYPASS_EN
  assign bypass = !pipe_real && fifo_empty && ll_valid && (ll_waddr != ZERO_ADDR);
`else
  assign bypass = 1'b0;
`endif

  // ll_ready depends on current occupancy only; address 0 completes the
  // handshake but is never stored.
  assign ll_ready = !fifo_full;
  assign push     = ll_valid && !fifo_full && (ll_waddr != ZERO_ADDR) && !bypass;

  wb_ll_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (ll_waddr),
    .push_data  (ll_wdata),
    .pop        (pop),
    .kill_en    (pipe_real),
    .kill_addr  (pipe_waddr),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  // A superseded head is still popped but produces an idle write slot.
  always_comb begin
    wb_d = '{we: WE_OFF, addr: ZERO_ADDR, data: ZERO_WORD};
    if (pipe_real)
      wb_d = '{we: WE_ON, addr: pipe_waddr, data: pipe_wdata};
    else if (pop && head_valid)
      wb_d = '{we: WE_ON, addr: head_addr, data: head_data};
    else if (bypass)
      wb_d = '{we: WE_ON, addr: ll_waddr, data: ll_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) wb_q <= '{we: WE_OFF, addr: ZERO_ADDR, data: ZERO_WORD};
    else                   wb_q <= wb_d;
  end

  assign we    = wb_q.we;
  assign waddr = wb_q.addr;
  assign wdata = wb_q.data;

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_match
    assign match1[g] = ent_valid[g] && (ent_addr[g] == chk_addr1);
    assign match2[g] = ent_valid[g] && (ent_addr[g] == chk_addr2);
  end

  assign pend_hit1 = (chk_addr1 != ZERO_ADDR) && (|match1);
  assign pend_hit2 = (chk_addr2 != ZERO_ADDR) && (|match2);

  // Saturates at the limit; stall_req stays up through the pop cycle and
  // drops once the pop clears the count.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE)      starve_cnt <= '0;
    else if (pop || fifo_empty) starve_cnt <= '0;
    else if (!stall_req)        starve_cnt <= starve_cnt + 1'b1;
  end

  assign stall_req = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, ll_valid, ll_ready, we, pend_hit1, pend_hit2, stall_req;
  logic [4:0]  pipe_waddr, ll_waddr, waddr, chk_addr1, chk_addr2;
  logic [31:0] pipe_wdata, ll_wdata, wdata;

  always #5 clk = ~clk;

  regfile_wb_arb #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_waddr   (ll_waddr),
    .ll_wdata   (ll_wdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .pend_hit1  (pend_hit1),
    .pend_hit2  (pend_hit2),
    .stall_req  (stall_req)
  );

  // Reference model: ordered list of queued results plus a blocked-cycle tally.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } qent_t;

  qent_t       q[$];
  int          starve;
  logic        ewe;
  logic [4:0]  ewa;
  logic [31:0] ewd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit pr, popm, byp, pushm;
    pr    = pipe_we && (pipe_waddr != 5'd0);
    popm  = !pr && (q.size() != 0);
    byp   = 1'b0;
`ifdef WB_LL_BYPASS_EN
    byp   = !pr && (q.size() == 0) && ll_valid && (ll_waddr != 5'd0);
`endif
    pushm = ll_valid && (q.size() < DEPTH) && (ll_waddr != 5'd0) && !byp;
    ewe = 1'b0; ewa = 5'd0; ewd = 32'd0;
    if (rst) begin
      q.delete();
      starve = 0;
      return;
    end
    if (pr) begin
      ewe = 1'b1; ewa = pipe_waddr; ewd = pipe_wdata;
    end else if (popm && q[0].live) begin
      ewe = 1'b1; ewa = q[0].addr; ewd = q[0].data;
    end else if (byp) begin
      ewe = 1'b1; ewa = ll_waddr; ewd = ll_wdata;
    end
    if (popm) starve = 0;
    else if (q.size() != 0) starve++;
    else starve = 0;
    if (pr) foreach (q[i]) if (q[i].addr == pipe_waddr) q[i].live = 1'b0;
    if (popm) void'(q.pop_front());
    if (pushm) q.push_back('{ll_waddr, ll_wdata, 1'b1});
  endtask

  // Called with inputs already applied just after a rising edge.
  task automatic step();
    #1;
    check("ll_ready", {31'd0, ll_ready}, {31'd0, q.size() < DEPTH});
    check("pend_hit1", {31'd0, pend_hit1}, {31'd0, m_hit(chk_addr1)});
    check("pend_hit2", {31'd0, pend_hit2}, {31'd0, m_hit(chk_addr2)});
    check("stall_req", {31'd0, stall_req}, {31'd0, starve >= LIMIT});
    model_step();
    @(posedge clk);
    #1;
    check("we", {31'd0, we}, {31'd0, ewe});
    check("waddr", {27'd0, waddr}, {27'd0, ewa});
    check("wdata", wdata, ewd);
  endtask

  task automatic drive(input int pwe, input int pa, input int pd,
                       input int llv, input int lla, input int lld);
    pipe_we    = (pwe != 0);
    pipe_waddr = 5'(pa);
    pipe_wdata = 32'(pd);
    ll_valid   = (llv != 0);
    ll_waddr   = 5'(lla);
    ll_wdata   = 32'(lld);
  endtask

  typedef struct {
    int pwe, pa, pd, llv, lla, lld, c1;
    int hit1, rdy, ewe, ewa, ewd;
  } vec_t;

  function automatic vec_t mk(input int pwe, input int pa, input int pd,
                              input int llv, input int lla, input int lld, input int c1,
                              input int hit1, input int rdy,
                              input int xwe, input int xwa, input int xwd);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.llv = llv; v.lla = lla; v.lld = lld; v.c1 = c1;
    v.hit1 = hit1; v.rdy = rdy; v.ewe = xwe; v.ewa = xwa; v.ewd = xwd;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 0, 9, 0, 1, 1, 5, 32'h1234_5678);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
`ifdef WB_LL_BYPASS_EN
    tbl[2]  = mk(0, 0, 0, 1, 9, 32'hAAAA_0001, 9, 0, 1, 1, 9, 32'hAAAA_0001);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
`else
    tbl[2]  = mk(0, 0, 0, 1, 9, 32'hAAAA_0001, 9, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 9, 1, 1, 1, 9, 32'hAAAA_0001);
`endif
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 7, 32'h77, 1, 3, 32'h11, 3, 0, 1, 1, 7, 32'h77);
    tbl[6]  = mk(1, 3, 32'h22, 0, 0, 0, 3, 1, 1, 1, 3, 32'h22);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 32'hBEEF, 1, 0, 32'hDEAD, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 12, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Reset entry
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk_addr1 = 5'd0;
    chk_addr2 = 5'd0;
    @(posedge clk);
    #1;
    q.delete(); starve = 0; ewe = 1'b0; ewa = 5'd0; ewd = 32'd0;
    step();
    rst = 1'b0;

    // Directed vectors: single writes, ll latency, supersede, address 0
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].llv, tbl[i].lla, tbl[i].lld);
      chk_addr1 = 5'(tbl[i].c1);
      chk_addr2 = 5'd0;
      #1;
      check("tbl_hit1", {31'd0, pend_hit1}, 32'(tbl[i].hit1));
      check("tbl_ready", {31'd0, ll_ready}, 32'(tbl[i].rdy));
      step();
      check("tbl_we", {31'd0, we}, 32'(tbl[i].ewe));
      check("tbl_waddr", {27'd0, waddr}, 32'(tbl[i].ewa));
      check("tbl_wdata", wdata, 32'(tbl[i].ewd));
    end

    // Fill the queue behind continuous pipe writes, then starve it
    chk_addr1 = 5'd1;
    chk_addr2 = 5'd4;
    for (int k = 0; k < 4; k++) begin
      drive(1, 20, k, 1, k + 1, 32'hC0 + k);
      step();
    end
    drive(1, 20, 32'h100, 0, 0, 0);
    #1;
    check("full_ready", {31'd0, ll_ready}, 32'd0);
    step();
    for (int k = 0; k < 3; k++) step();
    #1;
    check("stall_before_limit", {31'd0, stall_req}, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("stall_at_limit", {31'd0, stall_req}, 32'd1);
    step();
    check("first_pop_we", {31'd0, we}, 32'd1);
    check("first_pop_addr", {27'd0, waddr}, 32'd1);
    check("first_pop_data", wdata, 32'hC0);
    drive(1, 21, 32'h200, 0, 0, 0);
    #1;
    check("stall_cleared", {31'd0, stall_req}, 32'd0);
    step();
    for (int k = 0; k < 7; k++) step();

    // Reset with three entries queued and stall raised
    rst = 1'b1;
    chk_addr1 = 5'd2;
    chk_addr2 = 5'd3;
    #1;
    check("pre_rst_stall", {31'd0, stall_req}, 32'd1);
    check("pre_rst_hit1", {31'd0, pend_hit1}, 32'd1);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_we", {31'd0, we}, 32'd0);
    check("post_rst_stall", {31'd0, stall_req}, 32'd0);
    check("post_rst_hit1", {31'd0, pend_hit1}, 32'd0);
    check("post_rst_hit2", {31'd0, pend_hit2}, 32'd0);
    check("post_rst_ready", {31'd0, ll_ready}, 32'd1);
    step();

    // Random traffic in phases of differing pipeline load
    for (int c = 0; c < 900; c++) begin
      int unsigned pct;
      pct = (c / 150) % 3 == 0 ? 92 : ((c / 150) % 3 == 1 ? 30 : 65);
      rst        = ($urandom_range(0, 99) == 0);
      pipe_we    = ($urandom_range(0, 99) < pct);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      ll_valid   = ($urandom_range(0, 99) < 55);
      ll_waddr   = 5'($urandom_range(0, 7));
      ll_wdata   = $urandom;
      chk_addr1  = 5'($urandom_range(0, 7));
      chk_addr2  = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, depth of the long-latency result queue (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, cycles a queued result may wait before stall_req is raised.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline (MEM/WB) write request
- pipe_waddr  in  5  pipeline destination
- pipe_wdata  in  32  pipeline result
- ll_valid  in  1  long-latency unit (div/load-miss) result valid
- ll_ready  out  1  queue can accept
- ll_waddr  in  5  long-latency destination
- ll_wdata  in  32  long-latency result
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- chk_addr1  in  5  decode read-port-1 address to check
- chk_addr2  in  5  decode read-port-2 address to check
- pend_hit1  out  1  chk_addr1 has a queued write
- pend_hit2  out  1  chk_addr2 has a queued write
- stall_req  out  1  request pipeline stall to drain the queue

Function
REQ-004 SHALL register we/waddr/wdata; a source selected in cycle n drives them in cycle n+1 for exactly one cycle.
REQ-005 SHALL treat pipe_we=1 with pipe_waddr!=0 as a real pipe write; it always wins the output slot.
REQ-006 SHALL treat pipe_we=0 or pipe_waddr=0 as a free slot; in a free slot with the queue non-empty, SHALL pop the head entry to the output.
REQ-007 SHALL drive we=0, waddr=0, wdata=0 in any cycle following a cycle with no selected source.
REQ-008 SHALL drive ll_ready = !full, combinationally from current occupancy only (no push on a full queue even if a pop occurs that cycle).
REQ-009 SHALL push (ll_waddr, ll_wdata) when ll_valid && ll_ready && ll_waddr!=0; with ll_waddr=0 SHALL accept the handshake and discard the entry.
REQ-010 SHALL pop in FIFO order; simultaneous push and pop when neither full nor empty SHALL keep occupancy unchanged.
REQ-011 SHALL, when a real pipe write's pipe_waddr matches valid queued entries, invalidate those entries (younger pipe write supersedes); invalidated entries are popped without asserting we.
REQ-012 SHALL drive pend_hitN=1 combinationally iff chk_addrN!=0 and matches any valid queued entry; the output register is excluded.
REQ-013 SHALL count consecutive cycles with the queue non-empty and no pop; at count = STARVE_LIMIT SHALL assert stall_req, held until the cycle after the next pop, then clear the count.
REQ-014 SHALL never write register 0 (we=1 implies waddr!=0).

Reset
REQ-015 SHALL, on rst=1 at a clk edge, empty the queue, invalidate all entries, clear the starvation count, and drive we=0, waddr=0, wdata=0, stall_req=0 the next cycle.
REQ-016 SHALL drop in-flight queued results on reset mid-operation; ll_ready=1 the first cycle after reset deasserts.

Configuration
REQ-017 SHALL honour macro WB_LL_BYPASS_EN: when defined, a valid ll result with queue empty and a free slot SHALL go straight to the output register (latency 1) without being queued; when undefined, every ll result SHALL be queued (minimum latency 2: push n, pop n+1, we at n+2).

Structure
REQ-018 SHALL take data width (32), register address width (5), reset/write-enable polarity and zero-word constants from the shared global definitions include used by the register file.
REQ-019 SHALL implement the queue as one sub-module, wb_ll_fifo, exposing per-entry valid/address for match logic and a kill-by-address input.

Verification
REQ-020 Pipe write addr 5 data 0x1234_5678 in cycle 0, queue empty -> we=1, waddr=5, wdata=0x1234_5678 in cycle 1 only.
REQ-021 ll result addr 9 data 0xAAAA_0001, pipe idle -> we at cycle 2 (macro undefined) or cycle 1 (WB_LL_BYPASS_EN); pend_hit1 with chk_addr1=9 high only while queued.
REQ-022 Four ll pushes while pipe writes every cycle -> ll_ready=0 after 4th; stall_req=1 after 8 blocked cycles; first free slot pops entry 1 in order, stall_req clears next cycle.
REQ-023 Queued addr 3 = 0x11, then pipe write addr 3 = 0x22 -> only 0x22 written to reg 3; pend_hit for addr 3 drops the cycle after the pipe write.
REQ-024 ll result to addr 0 and pipe write to addr 0 -> handshake completes, we stays 0, queue occupancy unchanged.
REQ-025 rst=1 with 3 entries queued and stall_req=1 -> next cycle queue empty, we=0, stall_req=0, pend_hit1/2=0, ll_ready=1 after release.
